multi_mode_counter: RTL and testbench

- Parametrised up/down counter with selectable output code: binary, Gray or packed BCD.
- Successor to the team's fixed 3-bit Gray/sequence counter, generalised in width, with direction control, synchronous load, enable, terminal-count and wrap outputs.
- The odd-parity flag is retained.
- Feeds display drivers and position encoders in the same design.

---
 rtl/multi_mode_counter.sv | 129 ++++++++++++
 tb/tb_multi_mode_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_counter.sv
// Up/down counter with selectable output code (binary, Gray, packed BCD),
// synchronous load, terminal-count, wrap pulse and odd-parity flag.
module multi_mode_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Enable,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic [1:0]       Mode,
    output logic [WIDTH-1:0] Counter,
    output logic             Flag,
    output logic             Terminal,
    output logic             Wrap
);

    localparam int unsigned     Digits   = WIDTH / 4;
    localparam logic [1:0]      ModeGray = 2'b01;
    localparam logic [1:0]      ModeBcd  = 2'b10;
    localparam logic [WIDTH-1:0] BcdMax  = {Digits{4'h9}};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [1:0]       prev_mode_q;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = 1; i < int'(WIDTH); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // Out-of-range BCD digits saturate at 9.
    function automatic logic [WIDTH-1:0] bcd_clamp(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        for (int i = 0; i < int'(Digits); i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Per-digit +/-1 with ripple carry (up) or borrow (down).
    function automatic logic [WIDTH-1:0] bcd_step(input logic [WIDTH-1:0] v, input logic up);
        logic [WIDTH-1:0] r;
        logic [3:0]       d;
        logic             c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < int'(Digits); i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    // Limits are judged in the code the count is currently held in.
    assign at_zero  = (count_q == '0);
    assign at_max   = (prev_mode_q == ModeBcd) ? (count_q == BcdMax) : (&count_q);
    assign Terminal = Enable & (Up ? at_max : at_zero);
    assign Counter  = counter_q;
    assign Flag     = ^counter_q;
    assign Wrap     = wrap_q;

    // Next count: mode change > load > step > hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (Mode != prev_mode_q) begin
            count_d = '0;
        end else if (Load) begin
            if (Mode == ModeBcd) begin
                count_d = bcd_clamp(LoadValue);
            end else if (Mode == ModeGray) begin
                count_d = gray_to_bin(LoadValue);
            end else begin
                count_d = LoadValue;
            end
        end else if (Enable) begin
            wrap_d = Up ? at_max : at_zero;
            if (Mode == ModeBcd) begin
                count_d = bcd_step(count_q, Up);
            end else begin
                count_d = Up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
        counter_d = (Mode == ModeGray) ? (count_d ^ (count_d >> 1)) : count_d;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            count_q     <= '0;
            counter_q   <= '0;
            prev_mode_q <= 2'b00;
            wrap_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            counter_q   <= counter_d;
            prev_mode_q <= Mode;
            wrap_q      <= wrap_d;
        end
    end

endmodule

// File: tb/tb_multi_mode_counter.sv
// Bench for multi_mode_counter: a 4-bit and an 8-bit instance share stimulus and are
// compared each cycle against a numeric model of the counting rules.
module tb_multi_mode_counter;

    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       Enable = 1'b0;
    logic       Up = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] LoadValue = 8'h00;
    logic [1:0] Mode = 2'b00;

    logic [3:0] c4;
    logic [7:0] c8;
    logic       f4, f8, t4, t8, w4, w8;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: numeric value, mode in force, pending wrap.
    int         mval[2];
    logic [1:0] mprev[2];
    int         mwrap[2];
    int         widths[2] = '{4, 8};

    always #5 Clock = ~Clock;

    multi_mode_counter #(.WIDTH(4)) dut4 (
        .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Up(Up), .Load(Load),
        .LoadValue(LoadValue[3:0]), .Mode(Mode),
        .Counter(c4), .Flag(f4), .Terminal(t4), .Wrap(w4)
    );

    multi_mode_counter #(.WIDTH(8)) dut8 (
        .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Up(Up), .Load(Load),
        .LoadValue(LoadValue), .Mode(Mode),
        .Counter(c8), .Flag(f8), .Terminal(t8), .Wrap(w8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int max_of(input int w, input logic [1:0] m);
        return (m == 2'b10) ? (10 ** (w / 4)) - 1 : (1 << w) - 1;
    endfunction

    function automatic int encode(input int v, input int w, input logic [1:0] m);
        int r, x;
        if (m == 2'b01) return v ^ (v >> 1);
        if (m != 2'b10) return v;
        r = 0;
        x = v;
        for (int i = 0; i < w / 4; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int decode(input int raw, input int w, input logic [1:0] m);
        int r, s, d;
        if (m == 2'b01) begin
            r = raw;
            s = raw >> 1;
            while (s != 0) begin
                r = r ^ s;
                s = s >> 1;
            end
            return r;
        end
        if (m != 2'b10) return raw;
        r = 0;
        for (int i = w / 4 - 1; i >= 0; i--) begin
            d = (raw >> (4 * i)) & 15;
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mval[k]  = 0;
            mprev[k] = 2'b00;
            mwrap[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        int w, mx, raw;
        w   = widths[k];
        raw = (k == 0) ? int'(LoadValue[3:0]) : int'(LoadValue);
        if (!ResetN) begin
            mval[k] = 0; mprev[k] = 2'b00; mwrap[k] = 0;
        end else if (Mode != mprev[k]) begin
            mval[k] = 0; mprev[k] = Mode; mwrap[k] = 0;
        end else if (Load) begin
            mval[k] = decode(raw, w, Mode); mwrap[k] = 0;
        end else if (Enable) begin
            mx = max_of(w, Mode);
            if (Up) begin
                mwrap[k] = (mval[k] == mx) ? 1 : 0;
                mval[k]  = (mval[k] == mx) ? 0 : mval[k] + 1;
            end else begin
                mwrap[k] = (mval[k] == 0) ? 1 : 0;
                mval[k]  = (mval[k] == 0) ? mx : mval[k] - 1;
            end
        end else begin
            mwrap[k] = 0;
        end
    endtask

    function automatic int exp_term(input int k);
        if (!Enable) return 0;
        if (Up) return (mval[k] == max_of(widths[k], mprev[k])) ? 1 : 0;
        return (mval[k] == 0) ? 1 : 0;
    endfunction

    task automatic check_all();
        int e4, e8;
        e4 = encode(mval[0], 4, mprev[0]);
        e8 = encode(mval[1], 8, mprev[1]);
        check("cnt4",  32'(c4), e4);
        check("cnt8",  32'(c8), e8);
        check("flag4", 32'(f4), 32'($countones(e4) % 2));
        check("flag8", 32'(f8), 32'($countones(e8) % 2));
        check("term4", 32'(t4), exp_term(0));
        check("term8", 32'(t8), exp_term(1));
        check("wrap4", 32'(w4), mwrap[0]);
        check("wrap8", 32'(w8), mwrap[1]);
    endtask

    // Apply inputs just after an edge, check pre-edge state, then clock once.
    task automatic step(input logic en, input logic up, input logic ld,
                        input logic [7:0] lv, input logic [1:0] md);
        Enable = en; Up = up; Load = ld; LoadValue = lv; Mode = md;
        #1;
        check_all();
        @(posedge Clock);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    logic [3:0] gray_seq[17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    initial begin
        model_reset();
        #12;
        ResetN = 1'b1;

        // Gray up from reset: first edge clears on the mode change.
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
        check("gray_seq0", 32'(c4), 32'(gray_seq[0]));
        for (int i = 1; i < 17; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
            check("gray_seq", 32'(c4), 32'(gray_seq[i]));
        end
        check("gray_wrap", 32'(w4), 32'd1);

        // BCD load, count through 99 -> 00, down from 00, clamp on load.
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'b10);
        step(1'b0, 1'b1, 1'b1, 8'h98, 2'b10);
        check("bcd_load", 32'(c8), 32'h98);
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'b10);
        check("bcd_99", 32'(c8), 32'h99);
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'b10);
        check("bcd_00", 32'(c8), 32'h00);
        check("bcd_wrap", 32'(w8), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 2'b10);
        check("bcd_down", 32'(c8), 32'h99);
        step(1'b0, 1'b0, 1'b1, 8'hA7, 2'b10);
        check("bcd_clamp", 32'(c8), 32'h97);

        // Binary down through zero, then load beats enable.
        step(1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
        check("bin_down", 32'(c4), 32'hF);
        check("bin_wrap", 32'(w4), 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'h05, 2'b00);
        check("bin_load_en", 32'(c4), 32'h5);

        // Gray load, step up, reload, step down.
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
        step(1'b0, 1'b1, 1'b1, 8'h06, 2'b01);
        check("gray_load", 32'(c4), 32'h6);
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
        check("gray_up", 32'(c4), 32'h7);
        step(1'b0, 1'b1, 1'b1, 8'h06, 2'b01);
        step(1'b1, 1'b0, 1'b0, 8'h00, 2'b01);
        check("gray_down", 32'(c4), 32'h2);

        // Mode change wins over load and enable.
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        step(1'b0, 1'b1, 1'b1, 8'h09, 2'b00);
        step(1'b1, 1'b1, 1'b1, 8'h33, 2'b10);
        check("mchg_cnt", 32'(c8), 32'h00);
        check("mchg_wrap", 32'(w8), 32'd0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'b10);
        check("mchg_next", 32'(c8), 32'h01);

        // Asynchronous reset mid-cycle while counting at 0xC.
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        step(1'b0, 1'b1, 1'b1, 8'h0B, 2'b00);
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'b00);
        check("pre_rst", 32'(c4), 32'hC);
        #2;
        ResetN = 1'b0;
        #1;
        model_reset();
        check("rst_cnt", 32'(c4), 32'h0);
        check("rst_flag", 32'(f4), 32'd0);
        check("rst_wrap", 32'(w4), 32'd0);
        @(posedge Clock);
        #1;
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'b00);
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'b00);
        check("rst_hold", 32'(c8), 32'h0);
        ResetN = 1'b1;

        // Randomised phase: mostly counting, occasional loads, mode changes and resets.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] md;
            md = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : Mode;
            if ($urandom_range(0, 99) == 0) begin
                #2;
                ResetN = 1'b0;
                #1;
                model_reset();
                check("rnd_rst", 32'(c8), 32'h0);
                @(posedge Clock);
                #1;
                ResetN = 1'b1;
            end
            step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                 8'($urandom), md);
        end
        #1;
        check_all();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
